// File: rtl/cu_seq_if.sv
// Control-unit bus: IR opcode, flags and run in; datapath control word and T-state out.
interface cu_seq_if #(
    parameter int unsigned NSTATES = 6,
    parameter int unsigned OP_W    = 4
);
    logic               run;
    logic [OP_W-1:0]    opcode;
    logic               Z;
    logic               C;
    logic               Cp, Ep, Lp;
    logic               nCE, nLi, nEi, nLa, nLb, nLo;
    logic               Ea, Eu, Su;
    logic               nHLT;
    logic [NSTATES-1:0] state;

    modport master (
        output run, opcode, Z, C,
        input  Cp, Ep, Lp, nCE, nLi, nEi, nLa, nLb, nLo, Ea, Eu, Su, nHLT, state
    );

    modport slave (
        input  run, opcode, Z, C,
        output Cp, Ep, Lp, nCE, nLi, nEi, nLa, nLb, nLo, Ea, Eu, Su, nHLT, state
    );
endinterface

// File: rtl/cu_seq.sv
// SAP-1 style control unit: one-hot T-state ring, opcode decode, jumps and sticky halt.
// Define CU_SEQ_SHORT_CYCLE_EN to return to T1 right after an instruction's last active T-state.
module cu_seq #(
    parameter int unsigned NSTATES = 6,
    parameter int unsigned OP_W    = 4
) (
    input  logic    CLK,
    input  logic    nCLR,
    cu_seq_if.slave bus,
    output logic    CS,
    output logic    nWE
);
    if (NSTATES < 4 || NSTATES > 16) begin : g_bad_nstates
        $error("cu_seq: NSTATES must be in 4..16");
    end
    if (OP_W < 4) begin : g_bad_opw
        $error("cu_seq: OP_W must be at least 4");
    end

    typedef enum logic [1:0] {M_PROG, M_RUN, M_HALT} mode_t;
    typedef enum logic [3:0] {
        OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_JZ, OP_JC, OP_OUT, OP_HLT, OP_NOP
    } op_t;

    typedef struct packed {
        logic Cp, Ep, Lp, CS, nCE, nLi, nEi, nLa, nLb, nLo, Ea, Eu, Su, nHLT;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        Cp: 1'b0, Ep: 1'b0, Lp: 1'b0, CS: 1'b0,
        nCE: 1'b1, nLi: 1'b1, nEi: 1'b1, nLa: 1'b1, nLb: 1'b1, nLo: 1'b1,
        Ea: 1'b0, Eu: 1'b0, Su: 1'b0, nHLT: 1'b1
    };
    localparam logic [NSTATES-1:0] T1 = NSTATES'(1);
    localparam logic [NSTATES-1:0] T3 = NSTATES'(4);

    logic [NSTATES-1:0] state_q, state_d, ring_next;
    mode_t              mode_q, mode_d;
    ctrl_t              ctrl_q, ctrl_d;
    op_t                op;
    logic               addsub;

    always_comb begin
        op = OP_NOP;
        case (bus.opcode)
            OP_W'(4'h0): op = OP_LDA;
            OP_W'(4'h1): op = OP_ADD;
            OP_W'(4'h2): op = OP_SUB;
            OP_W'(4'h3): op = OP_JMP;
            OP_W'(4'h4): op = OP_JZ;
            OP_W'(4'h5): op = OP_JC;
            OP_W'(4'he): op = OP_OUT;
            OP_W'(4'hf): op = OP_HLT;
            default:     op = OP_NOP;
        endcase
    end

    assign addsub = (op == OP_ADD) || (op == OP_SUB);

    always_comb begin
        ring_next = {state_q[NSTATES-2:0], state_q[NSTATES-1]};
`ifdef CU_SEQ_SHORT_CYCLE_EN
        if ((state_q[2] && !addsub) || state_q[3]) begin
            ring_next = T1;
        end
`endif
    end

    // Controls are decoded from the state being entered, so they are registered for the whole T-state.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ctrl_d  = CTRL_IDLE;
        if (mode_q == M_HALT) begin
            state_d     = T3;
            ctrl_d.nHLT = 1'b0;
        end else if (!bus.run || !$onehot(state_q)) begin
            state_d = T1;
            mode_d  = M_PROG;
        end else begin
            state_d = (mode_q == M_RUN) ? ring_next : T1;
            mode_d  = M_RUN;
            if (state_d[0]) begin
                ctrl_d.Ep  = 1'b1;
                ctrl_d.CS  = 1'b1;
                ctrl_d.nCE = 1'b0;
                ctrl_d.nLi = 1'b0;
            end
            if (state_d[1]) begin
                ctrl_d.Cp = 1'b1;
            end
            if (state_d[2]) begin
                case (op)
                    OP_LDA: begin
                        ctrl_d.CS  = 1'b1;
                        ctrl_d.nCE = 1'b0;
                        ctrl_d.nEi = 1'b0;
                        ctrl_d.nLa = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl_d.CS  = 1'b1;
                        ctrl_d.nCE = 1'b0;
                        ctrl_d.nEi = 1'b0;
                        ctrl_d.nLb = 1'b0;
                    end
                    OP_JMP: begin
                        ctrl_d.nEi = 1'b0;
                        ctrl_d.Lp  = 1'b1;
                    end
                    OP_JZ, OP_JC: begin
                        if ((op == OP_JZ) ? bus.Z : bus.C) begin
                            ctrl_d.nEi = 1'b0;
                            ctrl_d.Lp  = 1'b1;
                        end
                    end
                    OP_OUT: begin
                        ctrl_d.Ea  = 1'b1;
                        ctrl_d.nLo = 1'b0;
                    end
                    OP_HLT: begin
                        ctrl_d.nHLT = 1'b0;
                        mode_d      = M_HALT;
                    end
                    default: ;
                endcase
            end
            if (state_d[3] && addsub) begin
                ctrl_d.Eu  = 1'b1;
                ctrl_d.Su  = (op == OP_SUB);
                ctrl_d.nLa = 1'b0;
            end
        end
    end

    always_ff @(negedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state_q <= T1;
            mode_q  <= M_PROG;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.state = state_q;
    assign bus.Cp    = ctrl_q.Cp;
    assign bus.Ep    = ctrl_q.Ep;
    assign bus.Lp    = ctrl_q.Lp;
    assign bus.nCE   = ctrl_q.nCE;
    assign bus.nLi   = ctrl_q.nLi;
    assign bus.nEi   = ctrl_q.nEi;
    assign bus.nLa   = ctrl_q.nLa;
    assign bus.nLb   = ctrl_q.nLb;
    assign bus.nLo   = ctrl_q.nLo;
    assign bus.Ea    = ctrl_q.Ea;
    assign bus.Eu    = ctrl_q.Eu;
    assign bus.Su    = ctrl_q.Su;
    assign bus.nHLT  = ctrl_q.nHLT;

    // In program mode the RAM belongs to the programmer.
    assign CS  = bus.run ? ctrl_q.CS : 1'bz;
    assign nWE = bus.run ? 1'b1 : 1'bz;
endmodule

// File: tb/tb_cu_seq.sv
// Directed, table-driven bench for cu_seq (NSTATES = 6, OP_W = 4).
module tb_cu_seq;
    localparam int unsigned NS = 6;

    // Control vector order: Cp Ep Lp CS nWE nCE nLi nEi nLa nLb nLo Ea Eu Su nHLT
    localparam logic [14:0] IDLE = 15'b000_0_1_111111_000_1;
    localparam logic [14:0] PROG = 15'b000_0_0_111111_000_1;
    localparam logic [14:0] F1   = 15'b010_1_1_001111_000_1;
    localparam logic [14:0] F2   = 15'b100_0_1_111111_000_1;
    localparam logic [14:0] LDA3 = 15'b000_1_1_010011_000_1;
    localparam logic [14:0] ADD3 = 15'b000_1_1_010101_000_1;
    localparam logic [14:0] JMP3 = 15'b001_0_1_110111_000_1;
    localparam logic [14:0] OUT3 = 15'b000_0_1_111110_100_1;
    localparam logic [14:0] HLT3 = 15'b000_0_1_111111_000_0;
    localparam logic [14:0] ADD4 = 15'b000_0_1_111011_010_1;
    localparam logic [14:0] SUB4 = 15'b000_0_1_111011_011_1;

`ifdef CU_SEQ_SHORT_CYCLE_EN
    localparam int unsigned LEN_LDA = 3;
    localparam int unsigned LEN_ADD = 4;
`else
    localparam int unsigned LEN_LDA = NS;
    localparam int unsigned LEN_ADD = NS;
`endif

    typedef struct {
        logic          run;
        logic [3:0]    op;
        logic          z;
        logic          c;
        logic [NS-1:0] st;
        logic [14:0]   ctrl;
    } vec_t;

    logic CLK = 1'b1;
    logic nCLR;
    wire  CS_w, nWE_w;
    int unsigned checks = 0;
    int unsigned errors = 0;
    vec_t vecs[$];

    cu_seq_if #(.NSTATES(NS), .OP_W(4)) bus ();

    cu_seq #(.NSTATES(NS), .OP_W(4)) dut (
        .CLK  (CLK),
        .nCLR (nCLR),
        .bus  (bus),
        .CS   (CS_w),
        .nWE  (nWE_w)
    );

    // Programmer pulls the RAM strobes low whenever the sequencer is not running.
    assign CS_w  = bus.run ? 1'bz : 1'b0;
    assign nWE_w = bus.run ? 1'bz : 1'b0;

    always #5 CLK = ~CLK;

    function automatic logic [14:0] obs();
        return {bus.Cp, bus.Ep, bus.Lp, CS_w, nWE_w, bus.nCE, bus.nLi, bus.nEi,
                bus.nLa, bus.nLb, bus.nLo, bus.Ea, bus.Eu, bus.Su, bus.nHLT};
    endfunction

    task automatic chk(input string name, input logic [NS-1:0] es, input logic [14:0] ec);
        logic [14:0] oc;
        oc = obs();
        checks++;
        if (bus.state !== es || oc !== ec) begin
            errors++;
            $display("FAIL %s: state=%b ctrl=%b required state=%b ctrl=%b",
                     name, bus.state, oc, es, ec);
        end
    endtask

    task automatic push(input logic run, input logic [3:0] op, input logic z, input logic c,
                        input logic [NS-1:0] st, input logic [14:0] ctrl);
        vec_t v;
        v.run = run; v.op = op; v.z = z; v.c = c; v.st = st; v.ctrl = ctrl;
        vecs.push_back(v);
    endtask

    // Fetch, T3 (and T4), then run dropped to abandon the rest of the instruction.
    task automatic push_instr(input logic [3:0] op, input logic z, input logic c,
                              input logic [14:0] t3, input logic [14:0] t4, input logic has_t4);
        push(1'b1, op, z, c, 6'b000001, F1);
        push(1'b1, op, z, c, 6'b000010, F2);
        push(1'b1, op, z, c, 6'b000100, t3);
        if (has_t4) push(1'b1, op, z, c, 6'b001000, t4);
        push(1'b0, op, z, c, 6'b000001, PROG);
    endtask

    task automatic wrap_len(input logic [3:0] op, input int unsigned exp_len, input string name);
        int unsigned n;
        n = 0;
        bus.opcode = op;
        bus.run    = 1'b1;
        @(posedge CLK);
        chk({name, "_t1"}, 6'b000001, F1);
        do begin
            @(posedge CLK);
            n++;
        end while (bus.state != 6'b000001 && n < 20);
        checks++;
        if (n != exp_len) begin
            errors++;
            $display("FAIL %s: took %0d states, required %0d", name, n, exp_len);
        end
        bus.run = 1'b0;
        @(posedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [14:0] exp_c;

        push(1'b0, 4'h1, 1'b0, 1'b0, 6'b000001, PROG);
        push(1'b0, 4'h1, 1'b0, 1'b0, 6'b000001, PROG);
        push_instr(4'h2, 1'b0, 1'b0, ADD3, SUB4, 1'b1);
        push_instr(4'h1, 1'b0, 1'b0, ADD3, ADD4, 1'b1);
        push_instr(4'h0, 1'b0, 1'b0, LDA3, IDLE, 1'b0);
        push_instr(4'h4, 1'b0, 1'b1, IDLE, IDLE, 1'b0);
        push_instr(4'h4, 1'b1, 1'b0, JMP3, IDLE, 1'b0);
        push_instr(4'h5, 1'b1, 1'b0, IDLE, IDLE, 1'b0);
        push_instr(4'h5, 1'b0, 1'b1, JMP3, IDLE, 1'b0);
        push_instr(4'h3, 1'b0, 1'b0, JMP3, IDLE, 1'b0);
        push_instr(4'he, 1'b0, 1'b0, OUT3, IDLE, 1'b0);
        push_instr(4'h7, 1'b1, 1'b1, IDLE, IDLE, 1'b0);
        push_instr(4'ha, 1'b0, 1'b0, IDLE, IDLE, 1'b0);

        nCLR = 1'b1;
        bus.run = 1'b0;
        bus.opcode = 4'h1;
        bus.Z = 1'b0;
        bus.C = 1'b0;
        #2 nCLR = 1'b0;
        #1 chk("reset", 6'b000001, PROG);
        repeat (2) @(posedge CLK);
        nCLR = 1'b1;

        foreach (vecs[i]) begin
            bus.run    = vecs[i].run;
            bus.opcode = vecs[i].op;
            bus.Z      = vecs[i].z;
            bus.C      = vecs[i].c;
            @(posedge CLK);
            chk($sformatf("vec%0d_op%h", i, vecs[i].op), vecs[i].st, vecs[i].ctrl);
        end

        bus.run = 1'b0;
        bus.opcode = 4'h1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            chk($sformatf("prog_hold%0d", i), 6'b000001, PROG);
        end

        wrap_len(4'h0, LEN_LDA, "wrap_lda");
        wrap_len(4'h1, LEN_ADD, "wrap_add");

        // Asynchronous reset in the middle of ADD T3.
        bus.opcode = 4'h1;
        bus.run = 1'b1;
        @(posedge CLK); chk("ar_t1", 6'b000001, F1);
        @(posedge CLK); chk("ar_t2", 6'b000010, F2);
        @(posedge CLK); chk("ar_t3", 6'b000100, ADD3);
        #2 nCLR = 1'b0;
        #1 chk("ar_async", 6'b000001, IDLE);
        @(posedge CLK);
        nCLR = 1'b1;
        @(posedge CLK); chk("ar_restart", 6'b000001, F1);
        bus.run = 1'b0;
        @(posedge CLK); chk("ar_stop", 6'b000001, PROG);

        // Sticky halt, run toggling ignored, cleared only by nCLR.
        bus.opcode = 4'hf;
        bus.run = 1'b1;
        @(posedge CLK); chk("hlt_t1", 6'b000001, F1);
        @(posedge CLK); chk("hlt_t2", 6'b000010, F2);
        @(posedge CLK); chk("hlt_t3", 6'b000100, HLT3);
        for (int i = 0; i < 20; i++) begin
            bus.run = (i % 3) != 0;
            bus.opcode = 4'h1;
            @(posedge CLK);
            exp_c = HLT3;
            if (!bus.run) exp_c[10] = 1'b0;
            chk($sformatf("hlt_hold%0d", i), 6'b000100, exp_c);
        end
        bus.run = 1'b1;
        #2 nCLR = 1'b0;
        #1 chk("hlt_clr", 6'b000001, IDLE);
        @(posedge CLK);
        nCLR = 1'b1;
        @(posedge CLK); chk("hlt_resume", 6'b000001, F1);
        @(posedge CLK); chk("hlt_resume_t2", 6'b000010, F2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
